// File: rtl/pc_seq_ctrl.sv
// Fetch-stage PC sequencer: boot sequence, next-PC selection, IF/ID stall and flush control.
// Optional performance counters are built when PC_SEQ_CTRL_PERF_EN is defined.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned BOOT_WAIT  = 2,
  parameter int unsigned PRED_BLANK = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_pc,
  input  logic             i_stall_mem,
  input  logic             i_stall_ld,
  input  logic             i_pred_taken,
  input  logic [31:0]      i_pred_target,
  input  logic             i_ex_mispred,
  input  logic [31:0]      i_ex_redirect_pc,
  output logic [31:0]      o_pc_next,
  output logic             o_en_pc,
  output logic             o_stall_ifid,
  output logic             o_flush_ifid,
  output logic             o_flush_idex,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_redirect_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    STALL   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [31:0] BOOT_LOAD  = 32'(BOOT_WAIT - 1);
  localparam logic [31:0] BLANK_LOAD = (PRED_BLANK == 0) ? 32'd0 : 32'(PRED_BLANK - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        in_recover;

  assign in_recover = (state_q == RECOVER);
  assign o_state    = state_q;

  // cnt_q is the boot countdown in BOOT and the prediction-blank countdown in RECOVER
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= BOOT;
      cnt_q   <= BOOT_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    o_pc_next    = '0;
    o_en_pc      = 1'b0;
    o_stall_ifid = 1'b0;
    o_flush_ifid = 1'b0;
    o_flush_idex = 1'b0;
    case (state_q)
      BOOT: begin
        o_flush_ifid = 1'b1;
        o_flush_idex = 1'b1;
        o_pc_next    = RESET_PC;
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          o_en_pc = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        // Stalls inside RECOVER keep the blank window open rather than dropping to STALL
        if (i_stall_mem) begin
          o_stall_ifid = 1'b1;
          state_d      = in_recover ? RECOVER : STALL;
        end else if (i_ex_mispred) begin
          o_en_pc      = 1'b1;
          o_pc_next    = {i_ex_redirect_pc[31:2], 2'b00};
          o_flush_ifid = 1'b1;
          o_flush_idex = 1'b1;
          if (PRED_BLANK == 0) begin
            state_d = RUN;
          end else begin
            state_d = RECOVER;
            cnt_d   = BLANK_LOAD;
          end
        end else if (i_stall_ld) begin
          o_stall_ifid = 1'b1;
          o_flush_idex = 1'b1;
          state_d      = in_recover ? RECOVER : STALL;
        end else if (i_pred_taken && !in_recover) begin
          o_en_pc   = 1'b1;
          o_pc_next = {i_pred_target[31:2], 2'b00};
          state_d   = RUN;
        end else begin
          o_en_pc   = 1'b1;
          o_pc_next = i_pc + 32'd4;
          if (in_recover && cnt_q != 32'd0) begin
            cnt_d   = cnt_q - 32'd1;
            state_d = RECOVER;
          end else begin
            state_d = RUN;
          end
        end
      end
    endcase
  end

`ifdef PC_SEQ_CTRL_PERF_EN
  logic             redirect_evt, stall_evt;
  logic [CNT_W-1:0] redirect_cnt_q, stall_cnt_q;

  assign redirect_evt = (state_q != BOOT) && !i_stall_mem && i_ex_mispred;
  assign stall_evt    = (state_q != BOOT) && (i_stall_mem || (!i_ex_mispred && i_stall_ld));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (redirect_evt) redirect_cnt_q <= redirect_cnt_q + 1'b1;
      if (stall_evt)    stall_cnt_q    <= stall_cnt_q + 1'b1;
    end
  end

  assign o_redirect_cnt = redirect_cnt_q;
  assign o_stall_cnt    = stall_cnt_q;
`else
  assign o_redirect_cnt = '0;
  assign o_stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl with RESET_PC=32'h100, BOOT_WAIT=2, PRED_BLANK=1.
module tb_pc_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_pc;
  logic        i_stall_mem, i_stall_ld, i_pred_taken, i_ex_mispred;
  logic [31:0] i_pred_target, i_ex_redirect_pc;
  logic [31:0] o_pc_next;
  logic        o_en_pc, o_stall_ifid, o_flush_ifid, o_flush_idex;
  logic [1:0]  o_state;
  logic [31:0] o_redirect_cnt, o_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pc_seq_ctrl #(
    .RESET_PC   (32'h0000_0100),
    .BOOT_WAIT  (2),
    .PRED_BLANK (1),
    .CNT_W      (32)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_pc             (i_pc),
    .i_stall_mem      (i_stall_mem),
    .i_stall_ld       (i_stall_ld),
    .i_pred_taken     (i_pred_taken),
    .i_pred_target    (i_pred_target),
    .i_ex_mispred     (i_ex_mispred),
    .i_ex_redirect_pc (i_ex_redirect_pc),
    .o_pc_next        (o_pc_next),
    .o_en_pc          (o_en_pc),
    .o_stall_ifid     (o_stall_ifid),
    .o_flush_ifid     (o_flush_ifid),
    .o_flush_idex     (o_flush_idex),
    .o_state          (o_state),
    .o_redirect_cnt   (o_redirect_cnt),
    .o_stall_cnt      (o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

`ifdef PC_SEQ_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic en, input logic st,
                     input logic fi, input logic fe);
    chk({tag, "_en"},    {31'd0, o_en_pc},      {31'd0, en});
    chk({tag, "_stall"}, {31'd0, o_stall_ifid}, {31'd0, st});
    chk({tag, "_fifid"}, {31'd0, o_flush_ifid}, {31'd0, fi});
    chk({tag, "_fidex"}, {31'd0, o_flush_idex}, {31'd0, fe});
  endtask

  // settle at the falling edge, then advance past the next rising edge
  task automatic settle();
    @(negedge i_clk);
  endtask

  task automatic advance();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1;
    i_pc = 32'h0; i_stall_mem = 0; i_stall_ld = 0; i_pred_taken = 0;
    i_ex_mispred = 0; i_pred_target = 32'h0; i_ex_redirect_pc = 32'h0;
    advance(); advance();

    settle();
    chk("rst_state", {30'd0, o_state}, 32'd0);
    chk("rst_pcnext", o_pc_next, 32'h100);
    ctl("rst", 0, 0, 1, 1);
    chk("rst_rcnt", o_redirect_cnt, 32'd0);
    chk("rst_scnt", o_stall_cnt, 32'd0);
    advance();

    i_rst = 1'b0;
    i_stall_ld = 1'b1; i_pred_taken = 1'b1;   // ignored in BOOT
    settle();
    ctl("boot0", 0, 0, 1, 1);
    advance();
    settle();
    ctl("boot1", 1, 0, 1, 1);
    chk("boot1_pcnext", o_pc_next, 32'h100);
    advance();

    i_stall_ld = 1'b0; i_pred_taken = 1'b0; i_pc = 32'h100;
    settle();
    chk("run_state", {30'd0, o_state}, 32'd1);
    chk("run_pcnext", o_pc_next, 32'h104);
    ctl("run", 1, 0, 0, 0);
    advance();

    i_pc = 32'h104; i_pred_taken = 1'b1; i_pred_target = 32'h203;
    settle();
    chk("pred_pcnext", o_pc_next, 32'h200);
    ctl("pred", 1, 0, 0, 0);
    advance();

    i_pc = 32'h200; i_pred_taken = 1'b0;
    i_ex_mispred = 1'b1; i_ex_redirect_pc = 32'h40; i_stall_ld = 1'b1;
    settle();
    chk("mis_pcnext", o_pc_next, 32'h40);
    ctl("mis", 1, 0, 1, 1);
    advance();

    i_ex_mispred = 1'b0; i_stall_ld = 1'b0;
    i_pc = 32'h40; i_pred_taken = 1'b1; i_pred_target = 32'h300;
    settle();
    chk("rec_state", {30'd0, o_state}, 32'd3);
    chk("rec_pcnext", o_pc_next, 32'h44);
    chk("rec_rcnt", o_redirect_cnt, PERF ? 32'd1 : 32'd0);
    advance();

    i_pred_taken = 1'b0; i_pc = 32'h44;
    i_stall_mem = 1'b1; i_ex_mispred = 1'b1; i_ex_redirect_pc = 32'h82;
    for (int i = 0; i < 3; i++) begin
      settle();
      ctl("memst", 0, 1, 0, 0);
      if (i > 0) chk("memst_state", {30'd0, o_state}, 32'd2);
      advance();
    end

    i_stall_mem = 1'b0;
    settle();
    chk("memrel_pcnext", o_pc_next, 32'h80);
    ctl("memrel", 1, 0, 1, 1);
    chk("memrel_scnt", o_stall_cnt, PERF ? 32'd3 : 32'd0);
    advance();

    i_ex_mispred = 1'b0; i_pc = 32'h80;
    settle();
    chk("rec2_state", {30'd0, o_state}, 32'd3);
    chk("rec2_pcnext", o_pc_next, 32'h84);
    chk("rec2_rcnt", o_redirect_cnt, PERF ? 32'd2 : 32'd0);
    advance();

    i_pc = 32'h84; i_stall_ld = 1'b1;
    settle();
    chk("ld_state", {30'd0, o_state}, 32'd1);
    ctl("ld", 0, 1, 0, 1);
    chk("ld_scnt_before", o_stall_cnt, PERF ? 32'd3 : 32'd0);
    advance();

    i_stall_ld = 1'b0;
    settle();
    chk("ldrel_state", {30'd0, o_state}, 32'd2);
    chk("ldrel_pcnext", o_pc_next, 32'h88);
    ctl("ldrel", 1, 0, 0, 0);
    chk("ld_scnt_after", o_stall_cnt, PERF ? 32'd4 : 32'd0);
    advance();

    i_pc = 32'hFFFF_FFFC;
    settle();
    chk("wrap_state", {30'd0, o_state}, 32'd1);
    chk("wrap_pcnext", o_pc_next, 32'h0);
    advance();

    i_stall_mem = 1'b1;
    advance();
    settle();
    chk("pre_rst_state", {30'd0, o_state}, 32'd2);
    i_rst = 1'b1;
    #1;
    chk("async_rst_state", {30'd0, o_state}, 32'd0);
    ctl("async_rst", 0, 0, 1, 1);
    chk("async_rst_rcnt", o_redirect_cnt, 32'd0);
    chk("async_rst_scnt", o_stall_cnt, 32'd0);
    advance();
    i_rst = 1'b0; i_stall_mem = 1'b0;
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
